// File: rtl/accel_lite_stream_ctrl_if.sv
// rtl/accel_lite_stream_ctrl_if.sv - AXI4-Lite slave and AXI-Stream master bundle for the stream controller
interface accel_lite_stream_ctrl_if #(
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int C_S_AXI_ADDR_WIDTH   = 4,
   parameter int C_M_AXIS_TDATA_WIDTH = 32
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
   logic [2:0]                        S_AXI_AWPROT;
   logic                              S_AXI_AWVALID;
   logic                              S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
   logic                              S_AXI_WVALID;
   logic                              S_AXI_WREADY;
   logic [1:0]                        S_AXI_BRESP;
   logic                              S_AXI_BVALID;
   logic                              S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
   logic [2:0]                        S_AXI_ARPROT;
   logic                              S_AXI_ARVALID;
   logic                              S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
   logic [1:0]                        S_AXI_RRESP;
   logic                              S_AXI_RVALID;
   logic                              S_AXI_RREADY;
   logic                              M_AXIS_TVALID;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA;
   logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
   logic                              M_AXIS_TLAST;
   logic                              M_AXIS_TREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY, M_AXIS_TREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY, M_AXIS_TREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
   );
endinterface

// File: rtl/accel_lite_stream_ctrl.sv
// rtl/accel_lite_stream_ctrl.sv - AXI4-Lite programmed generator of incrementing-data stream packets
module accel_lite_stream_ctrl #(
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int C_S_AXI_ADDR_WIDTH   = 4,
   parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
   input  logic ACLK,
   input  logic ARESETN,
   accel_lite_stream_ctrl_if.slave axi
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]                        state;
   logic                              awReady, bValid, arReady, rValid;
   logic [C_S_AXI_DATA_WIDTH-1:0]     rData, rdMux;
   logic [7:0]                        lenReg, lenLat, beatCnt;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]   seedReg, tData;
   logic                              tValid, tLast;
   logic [15:0]                       pktCnt;
   logic [1:0]                        wrAddr;
   logic                              wrFire, rdFire, startReq, clrReq, beatFire;
   logic [31:0]                       statusWord;
   logic                              unusedBits;

   assign wrAddr     = axi.S_AXI_AWADDR[3:2];
   assign wrFire     = awReady & axi.S_AXI_AWVALID & axi.S_AXI_WVALID;
   assign rdFire     = arReady & axi.S_AXI_ARVALID;
   assign startReq   = wrFire && (wrAddr == 2'd0) && axi.S_AXI_WDATA[0];
   assign clrReq     = wrFire && (wrAddr == 2'd0) && axi.S_AXI_WDATA[1];
   assign beatFire   = tValid & axi.M_AXIS_TREADY;
   assign statusWord = {pktCnt, beatCnt, 7'd0, state == SEND};
   assign unusedBits = ^{axi.S_AXI_AWPROT, axi.S_AXI_ARPROT, axi.S_AXI_AWADDR[1:0], axi.S_AXI_ARADDR[1:0]};

   // Write channel: AWREADY/WREADY pulse together, blocked while a response is outstanding
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awReady <= 1'b0;
         bValid  <= 1'b0;
         lenReg  <= '0;
         seedReg <= '0;
      end else begin
         awReady <= !awReady && axi.S_AXI_AWVALID && axi.S_AXI_WVALID && !bValid;
         if (wrFire)
            bValid <= 1'b1;
         else if (axi.S_AXI_BREADY)
            bValid <= 1'b0;
         if (wrFire && wrAddr == 2'd1 && axi.S_AXI_WSTRB[0])
            lenReg <= axi.S_AXI_WDATA[7:0];
         if (wrFire && wrAddr == 2'd2)
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
               if (axi.S_AXI_WSTRB[b])
                  seedReg[8*b +: 8] <= axi.S_AXI_WDATA[8*b +: 8];
      end
   end

   always_comb begin
      rdMux = '0;
      case (axi.S_AXI_ARADDR[3:2])
         2'd1:    rdMux[7:0] = lenReg;
         2'd2:    rdMux      = seedReg;
         2'd3:    rdMux      = statusWord;
         default: rdMux      = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         arReady <= 1'b0;
         rValid  <= 1'b0;
         rData   <= '0;
      end else begin
         arReady <= !arReady && axi.S_AXI_ARVALID && !rValid;
         if (rdFire) begin
            rValid <= 1'b1;
            rData  <= rdMux;
         end else if (axi.S_AXI_RREADY) begin
            rValid <= 1'b0;
         end
      end
   end

   // Packet FSM; TLAST is precomputed one beat ahead so it is a plain register output
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state   <= IDLE;
         tValid  <= 1'b0;
         tLast   <= 1'b0;
         tData   <= '0;
         lenLat  <= '0;
         beatCnt <= '0;
         pktCnt  <= '0;
      end else begin
         if (state == IDLE) begin
            if (startReq && lenReg != 8'd0) begin
               state   <= SEND;
               tValid  <= 1'b1;
               tData   <= seedReg;
               tLast   <= (lenReg == 8'd1);
               lenLat  <= lenReg;
               beatCnt <= '0;
            end
         end else if (beatFire) begin
            beatCnt <= beatCnt + 8'd1;
            if (tLast) begin
               state  <= IDLE;
               tValid <= 1'b0;
               tLast  <= 1'b0;
            end else begin
               tData <= tData + 1'b1;
               tLast <= ({1'b0, beatCnt} + 9'd2 == {1'b0, lenLat});
            end
         end
         if (clrReq)
            pktCnt <= '0;
         else if (beatFire && tLast)
            pktCnt <= pktCnt + 16'd1;
      end
   end

   assign axi.S_AXI_AWREADY = awReady;
   assign axi.S_AXI_WREADY  = awReady;
   assign axi.S_AXI_BVALID  = bValid;
   assign axi.S_AXI_BRESP   = 2'b00;
   assign axi.S_AXI_ARREADY = arReady;
   assign axi.S_AXI_RVALID  = rValid;
   assign axi.S_AXI_RDATA   = rData;
   assign axi.S_AXI_RRESP   = 2'b00;
   assign axi.M_AXIS_TVALID = tValid;
   assign axi.M_AXIS_TDATA  = tData;
   assign axi.M_AXIS_TLAST  = tLast;
   assign axi.M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
endmodule

// File: tb/tb_accel_lite_stream_ctrl.sv
// tb/tb_accel_lite_stream_ctrl.sv - directed and randomized bench for accel_lite_stream_ctrl against a packet-level model
module tb_accel_lite_stream_ctrl;
   logic tb_ACLK = 1'b0;
   logic tb_ARESETN = 1'b0;
   always #5 tb_ACLK = ~tb_ACLK;

   accel_lite_stream_ctrl_if bus ();
   accel_lite_stream_ctrl dut (.ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .axi(bus));

   int passed = 0, total = 0, timeouts = 0;
   int cyc = 0, mode = 0, lastWrCyc = 0;
   int stallErr = 0, tvCnt = 0, rxBase = 0, stallBase = 0;
   logic [36:0] rxQ[$];
   int beatCyc[$];
   logic [15:0] pktModel = '0;
   logic [7:0]  lastBeats = '0;
   logic        prevStall = 1'b0, prevLast = 1'b0;
   logic [31:0] prevData = '0;

   always @(posedge tb_ACLK) cyc <= cyc + 1;

   // Stream observer: a handshake seen here completes at the following rising edge
   always @(negedge tb_ACLK) begin
      if (tb_ARESETN && prevStall &&
          !(bus.M_AXIS_TVALID === 1'b1 && bus.M_AXIS_TDATA === prevData && bus.M_AXIS_TLAST === prevLast))
         stallErr <= stallErr + 1;
      if (tb_ARESETN && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
         rxQ.push_back({bus.M_AXIS_TSTRB, bus.M_AXIS_TLAST, bus.M_AXIS_TDATA});
         beatCyc.push_back(cyc);
      end
      tvCnt     <= tvCnt + (bus.M_AXIS_TVALID ? 1 : 0);
      prevStall <= tb_ARESETN && bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
      prevData  <= bus.M_AXIS_TDATA;
      prevLast  <= bus.M_AXIS_TLAST;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge tb_ACLK);
      #1;
      case (mode)
         0: bus.M_AXIS_TREADY = 1'b1;
         1: bus.M_AXIS_TREADY = ~bus.M_AXIS_TREADY;
         2: bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
         3: bus.M_AXIS_TREADY = 1'b0;
         default: ;
      endcase
   endtask

   task automatic axiWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
      int n = 0;
      bus.S_AXI_AWADDR = a; bus.S_AXI_AWPROT = 3'($urandom); bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      while (bus.S_AXI_AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) timeouts++;
      tick();
      lastWrCyc = cyc;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      n = 0;
      while (bus.S_AXI_BVALID !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) timeouts++;
      resp = bus.S_AXI_BRESP;
      if (bus.S_AXI_BREADY) tick();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [1:0] r;
      axiWrite(a, d, 4'hF, r);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARPROT = 3'($urandom); bus.S_AXI_ARVALID = 1'b1;
      while (bus.S_AXI_ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) timeouts++;
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      n = 0;
      while (bus.S_AXI_RVALID !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) timeouts++;
      d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
      tick();
   endtask

   task automatic rdChk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0] r;
      rd(a, d, r);
      chk(tag, d, exp);
   endtask

   task automatic markStream();
      rxBase = rxQ.size();
      stallBase = stallErr;
   endtask

   task automatic checkRx(input int len, input logic [31:0] seed, input bit b2b);
      int n = 0;
      while (rxQ.size() - rxBase < len && n < 3000) begin tick(); n++; end
      repeat (4) tick();
      chk("beat count", rxQ.size() - rxBase, len);
      for (int k = 0; k < len && rxBase + k < rxQ.size(); k++) begin
         chk("beat data", rxQ[rxBase + k][31:0], seed + 32'(k));
         chk("beat strb/last", 32'(rxQ[rxBase + k][36:32]), {27'd0, 4'hF, k == len - 1});
      end
      chk("stall stability", stallErr - stallBase, 0);
      if (b2b && rxQ.size() - rxBase >= len) begin
         chk("first beat latency", beatCyc[rxBase], lastWrCyc);
         chk("back-to-back", beatCyc[rxBase + len - 1] - beatCyc[rxBase], len - 1);
      end
      pktModel++;
      lastBeats = 8'(len);
      rdChk("status after packet", 4'hC, {pktModel, lastBeats, 8'h00});
   endtask

   task automatic runPacket(input int len, input logic [31:0] seed, input bit b2b);
      wr(4'h4, 32'(len));
      wr(4'h8, seed);
      markStream();
      wr(4'h0, 32'h1);
      checkRx(len, seed, b2b);
   endtask

   initial begin
      logic [31:0] seedModel, d, x, s0;
      logic [3:0]  st;
      logic [1:0]  r;
      int n, tvBase;
      bit sawReady, bHeld;

      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
      bus.M_AXIS_TREADY = 1'b1;

      repeat (3) @(posedge tb_ACLK);
      #1;
      chk("reset handshakes", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                                    bus.S_AXI_RVALID, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST}), 32'd0);
      chk("reset tdata", bus.M_AXIS_TDATA, 32'd0);
      chk("reset rdata", bus.S_AXI_RDATA, 32'd0);
      tb_ARESETN = 1'b1;
      tick(); tick();
      rdChk("reset status", 4'hC, 32'd0);
      rdChk("reset len", 4'h4, 32'd0);

      mode = 0;
      runPacket(4, 32'h0101FFFF, 1'b1);

      wr(4'h8, 32'h0);
      axiWrite(4'h8, 32'hABCD0001, 4'b0011, r);
      chk("bresp", 32'(r), 32'd0);
      rd(4'h8, d, r);
      chk("seed strobed", d, 32'h00000001);
      chk("rresp", 32'(r), 32'd0);
      seedModel = 32'h00000001;
      for (int i = 0; i < 3; i++) begin
         x = $urandom;
         st = 4'($urandom_range(0, 15));
         axiWrite(4'h8, x, st, r);
         for (int b = 0; b < 4; b++)
            if (st[b]) seedModel[8*b +: 8] = x[8*b +: 8];
         rdChk("seed random strobe", 4'h8, seedModel);
      end
      wr(4'h4, 32'hFFFFFF07);
      rdChk("len upper bits", 4'h4, 32'h07);
      axiWrite(4'h4, 32'h55, 4'b1110, r);
      rdChk("len lane gated", 4'h4, 32'h07);
      rdChk("ctrl reads zero", 4'h0, 32'd0);

      mode = 1;
      runPacket(3, 32'hFFFFFFFF, 1'b0);

      mode = 0;
      wr(4'h4, 32'd0);
      tvBase = tvCnt;
      wr(4'h0, 32'h1);
      repeat (20) tick();
      chk("len0 no tvalid", tvCnt - tvBase, 0);
      rdChk("len0 status", 4'hC, {pktModel, lastBeats, 8'h00});

      // START and register writes while a stalled packet is in flight
      mode = 3;
      s0 = $urandom;
      x = $urandom;
      wr(4'h4, 32'd6);
      wr(4'h8, s0);
      markStream();
      wr(4'h0, 32'h1);
      wr(4'h4, 32'd2);
      wr(4'h8, x);
      wr(4'h0, 32'h1);
      mode = 0;
      checkRx(6, s0, 1'b0);
      rdChk("len updated in flight", 4'h4, 32'd2);
      rdChk("seed updated in flight", 4'h8, x);

      // CLR_CNT landing on the same edge as the TLAST handshake
      mode = 4;
      bus.M_AXIS_TREADY = 1'b0;
      x = $urandom;
      wr(4'h4, 32'd1);
      wr(4'h8, x);
      markStream();
      wr(4'h0, 32'h1);
      repeat (3) tick();
      bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'h2; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      tick();
      chk("clr awready", 32'(bus.S_AXI_AWREADY), 32'd1);
      bus.M_AXIS_TREADY = 1'b1;
      tick();
      bus.M_AXIS_TREADY = 1'b0;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      repeat (3) tick();
      chk("clr beat count", rxQ.size() - rxBase, 1);
      if (rxQ.size() > rxBase) chk("clr beat data", rxQ[rxBase][31:0], x);
      pktModel = '0;
      lastBeats = 8'd1;
      rdChk("clr wins", 4'hC, {pktModel, lastBeats, 8'h00});

      for (int i = 0; i < 4; i++) begin
         mode = 2;
         runPacket($urandom_range(1, 12), $urandom, 1'b0);
      end

      // Response backpressure blocks the next write
      mode = 0;
      bus.S_AXI_BREADY = 1'b0;
      axiWrite(4'h4, 32'd5, 4'hF, r);
      bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'd6; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      sawReady = 1'b0; bHeld = 1'b1;
      repeat (6) begin
         tick();
         if (bus.S_AXI_AWREADY) sawReady = 1'b1;
         if (!bus.S_AXI_BVALID) bHeld = 1'b0;
      end
      chk("bvalid held", 32'(bHeld), 32'd1);
      chk("awready blocked", 32'(sawReady), 32'd0);
      bus.S_AXI_BREADY = 1'b1;
      n = 0;
      while (bus.S_AXI_AWREADY !== 1'b1 && n < 20) begin tick(); n++; end
      chk("second write accepted", 32'(bus.S_AXI_AWREADY), 32'd1);
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      repeat (3) tick();
      rdChk("second write len", 4'h4, 32'd6);

      // Reset in the middle of an 8-beat packet
      wr(4'h4, 32'd8);
      wr(4'h8, 32'h12345678);
      markStream();
      wr(4'h0, 32'h1);
      n = 0;
      while (rxQ.size() - rxBase < 2 && n < 50) begin tick(); n++; end
      tb_ARESETN = 1'b0;
      #1;
      chk("reset drops tvalid", 32'(bus.M_AXIS_TVALID), 32'd0);
      chk("reset tlast/tdata", {bus.M_AXIS_TDATA[30:0], bus.M_AXIS_TLAST}, 32'd0);
      repeat (2) tick();
      tb_ARESETN = 1'b1;
      repeat (2) tick();
      chk("aborted packet beats", rxQ.size() - rxBase, 2);
      pktModel = '0;
      lastBeats = '0;
      rdChk("status after reset", 4'hC, 32'd0);
      rdChk("seed after reset", 4'h8, 32'd0);
      runPacket(8, $urandom, 1'b1);

      chk("handshake timeouts", timeouts, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
